// File: rtl/dmg_lcd_capture_pkg.sv
// Shared geometry, typed constants and the capture state type for the DMG LCD capture block.
// The typed constants let the counters compare and add without width casts at every use.
package dmg_pkg;

  localparam int H_PIXELS       = 160;
  localparam int V_LINES        = 144;
  localparam int BYTES_PER_LINE = 40;
  localparam int BANK_BYTES     = H_PIXELS * V_LINES / 4;

  localparam int XW = 8;   // x counts 0..H_PIXELS inclusive
  localparam int LW = 8;
  localparam int AW = 14;

  localparam logic [XW-1:0] X_END     = XW'(H_PIXELS);
  localparam logic [LW-1:0] LINE_LAST = LW'(V_LINES - 1);
  localparam logic [AW-1:0] LINE_STEP = AW'(BYTES_PER_LINE);
  localparam logic [AW-1:0] BANK_OFF  = AW'(BANK_BYTES);

  typedef enum logic {CAP_IDLE, CAP_ACTIVE} cap_state_t;

  // Byte address inside the framebuffer; xb is the pixel x already divided by 4.
  function automatic logic [AW-1:0] byte_addr(input logic bank, input logic [AW-1:0] lbase,
                                              input logic [XW-3:0] xb);
    return (bank ? BANK_OFF : '0) + lbase + AW'(xb);
  endfunction

endpackage

// File: rtl/dmg_lcd_capture_if.sv
// LCD stream in / framebuffer write port out of the capture block.
// master drives the LCD stream, slave is the capture block.
interface dmg_lcd_capture_if;
  import dmg_pkg::*;

  logic          capture_en;
  logic          lcd_vsync;
  logic          lcd_hsync;
  logic          lcd_pixel;
  logic [1:0]    lcd_color;
  logic          fb_we;
  logic [AW-1:0] fb_waddr;
  logic [7:0]    fb_wdata;
  logic          front_bank;
  logic          frame_done;
  logic          err_overrun;
  logic          err_short;

  modport master (
    output capture_en, lcd_vsync, lcd_hsync, lcd_pixel, lcd_color,
    input  fb_we, fb_waddr, fb_wdata, front_bank, frame_done, err_overrun, err_short
  );

  modport slave (
    input  capture_en, lcd_vsync, lcd_hsync, lcd_pixel, lcd_color,
    output fb_we, fb_waddr, fb_wdata, front_bank, frame_done, err_overrun, err_short
  );

endinterface

// File: rtl/dmg_lcd_capture_packer.sv
// Packs four 2-bit pixels into one byte, leftmost pixel in [7:6].
// A clear in the same cycle as a shift applies first, so that pixel starts a fresh byte.
module lcd_pixel_packer (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr_i,
  input  logic       shift_i,
  input  logic [1:0] color_i,
  output logic       byte_vld_o,
  output logic [7:0] byte_o
);

  logic [5:0] sh_q, sh_d, sh_e;
  logic [1:0] cnt_q, cnt_d, cnt_e;
  logic       vld_q, vld_d;
  logic [7:0] byte_q, byte_d;

  always_comb begin
    sh_e   = clr_i ? 6'd0 : sh_q;
    cnt_e  = clr_i ? 2'd0 : cnt_q;
    sh_d   = sh_e;
    cnt_d  = cnt_e;
    vld_d  = 1'b0;
    byte_d = byte_q;
    if (shift_i) begin
      if (cnt_e == 2'd3) begin
        byte_d = {sh_e, color_i};
        vld_d  = 1'b1;
        sh_d   = 6'd0;
        cnt_d  = 2'd0;
      end else begin
        sh_d  = {sh_e[3:0], color_i};
        cnt_d = cnt_e + 2'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      sh_q   <= '0;
      cnt_q  <= '0;
      vld_q  <= 1'b0;
      byte_q <= '0;
    end else begin
      sh_q   <= sh_d;
      cnt_q  <= cnt_d;
      vld_q  <= vld_d;
      byte_q <= byte_d;
    end
  end

  assign byte_vld_o = vld_q;
  assign byte_o     = byte_q;

endmodule

// File: rtl/dmg_lcd_capture.sv
// Captures the DMG LCD stream into a double-buffered 2bpp framebuffer.
// The front bank flips only after a complete, error-free frame.
module dmg_lcd_capture
  import dmg_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  dmg_lcd_capture_if.slave lcd
);

  logic          vs_q, hs_q, vs_rise, hs_rise;
  cap_state_t    state_q, state_d;
  logic [XW-1:0] x_q, x_d;
  logic [LW-1:0] line_q, line_d;
  logic [AW-1:0] lbase_q, lbase_d;
  logic          ok_q, ok_d;
  logic          drop_q, drop_d;
  logic          front_q, front_d;
  logic          done_q, done_d;
  logic          ovr_q, ovr_d;
  logic          short_q, short_d;
  logic [AW-1:0] waddr_q, waddr_d;
  logic          pk_clr, pk_shift, pk_vld;
  logic [7:0]    pk_byte;

  assign vs_rise = lcd.lcd_vsync & ~vs_q;
  assign hs_rise = lcd.lcd_hsync & ~hs_q;

  // Sync edges are resolved first; a pixel in the same cycle then lands at x=0 of the new line.
  always_comb begin
    state_d  = state_q;
    x_d      = x_q;
    line_d   = line_q;
    lbase_d  = lbase_q;
    ok_d     = ok_q;
    drop_d   = drop_q;
    front_d  = front_q;
    done_d   = 1'b0;
    ovr_d    = ovr_q;
    short_d  = short_q;
    waddr_d  = waddr_q;
    pk_clr   = 1'b0;
    pk_shift = 1'b0;

    if (vs_rise) begin
      pk_clr = 1'b1;
      if (state_q == CAP_ACTIVE) begin
        if (ok_q && line_q == LINE_LAST && x_q == X_END) begin
          front_d = ~front_q;
          done_d  = 1'b1;
        end else begin
          short_d = 1'b1;
        end
      end
      if (lcd.capture_en) begin
        state_d = CAP_ACTIVE;
        x_d     = '0;
        line_d  = '0;
        lbase_d = '0;
        ok_d    = 1'b1;
        drop_d  = 1'b0;
      end else begin
        state_d = CAP_IDLE;
      end
    end else if (hs_rise && state_q == CAP_ACTIVE) begin
      pk_clr = 1'b1;
      x_d    = '0;
      if (x_q != X_END) begin
        short_d = 1'b1;
        ok_d    = 1'b0;
      end
      // Too many lines: keep the line pointer in range and drop pixels until vsync.
      if (line_q == LINE_LAST) begin
        ovr_d  = 1'b1;
        ok_d   = 1'b0;
        drop_d = 1'b1;
      end else begin
        line_d  = line_q + 8'd1;
        lbase_d = lbase_q + LINE_STEP;
      end
    end

    if (lcd.lcd_pixel && state_d == CAP_ACTIVE && !drop_d) begin
      if (x_d == X_END) begin
        ovr_d = 1'b1;
        ok_d  = 1'b0;
      end else begin
        pk_shift = 1'b1;
        if (x_d[1:0] == 2'b11)
          waddr_d = byte_addr(~front_q, lbase_d, x_d[XW-1:2]);
        x_d = x_d + 8'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      vs_q    <= 1'b0;
      hs_q    <= 1'b0;
      state_q <= CAP_IDLE;
      x_q     <= '0;
      line_q  <= '0;
      lbase_q <= '0;
      ok_q    <= 1'b0;
      drop_q  <= 1'b0;
      front_q <= 1'b0;
      done_q  <= 1'b0;
      ovr_q   <= 1'b0;
      short_q <= 1'b0;
      waddr_q <= '0;
    end else begin
      vs_q    <= lcd.lcd_vsync;
      hs_q    <= lcd.lcd_hsync;
      state_q <= state_d;
      x_q     <= x_d;
      line_q  <= line_d;
      lbase_q <= lbase_d;
      ok_q    <= ok_d;
      drop_q  <= drop_d;
      front_q <= front_d;
      done_q  <= done_d;
      ovr_q   <= ovr_d;
      short_q <= short_d;
      waddr_q <= waddr_d;
    end
  end

  lcd_pixel_packer u_packer (
    .clk        (clk),
    .rst        (rst),
    .clr_i      (pk_clr),
    .shift_i    (pk_shift),
    .color_i    (lcd.lcd_color),
    .byte_vld_o (pk_vld),
    .byte_o     (pk_byte)
  );

  assign lcd.fb_we       = pk_vld;
  assign lcd.fb_wdata    = pk_byte;
  assign lcd.fb_waddr    = waddr_q;
  assign lcd.front_bank  = front_q;
  assign lcd.frame_done  = done_q;
  assign lcd.err_overrun = ovr_q;
  assign lcd.err_short   = short_q;

endmodule

// File: tb/tb_dmg_lcd_capture.sv
// Directed bench for dmg_lcd_capture: a frame-level model predicts every byte write and flag,
// and a per-cycle compare process checks the DUT against it.
module tb_dmg_lcd_capture;
  import dmg_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dmg_lcd_capture_if bus();
  dmg_lcd_capture dut (.clk(clk), .rst(rst), .lcd(bus));

  typedef struct { int addr; int data; } wr_t;
  wr_t exp_q[$];

  int checks = 0, errors = 0;
  bit chk_en = 1'b0;

  // model state
  bit m_active, m_ok, m_drop, m_front, m_ovr, m_short, m_done, m_pvs, m_phs;
  int m_x, m_line;
  int lbuf [H_PIXELS];

  // observed statistics per test segment
  int n_we, n_done, n_bad, a_min, a_max, last_addr, last_data;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic void m_reset();
    m_active = 0; m_ok = 0; m_drop = 0; m_front = 0; m_ovr = 0; m_short = 0;
    m_done = 0; m_pvs = 0; m_phs = 0; m_x = 0; m_line = 0;
  endfunction

  function automatic void m_step(input bit vs, input bit hs, input bit px,
                                 input logic [1:0] col, input bit cap);
    bit vr, hr;
    wr_t w;
    vr = vs && !m_pvs;
    hr = hs && !m_phs;
    m_pvs = vs; m_phs = hs; m_done = 0;
    if (vr) begin
      if (m_active) begin
        if (m_ok && m_line == V_LINES - 1 && m_x == H_PIXELS) begin
          m_front = !m_front; m_done = 1;
        end else m_short = 1;
      end
      m_active = cap; m_x = 0; m_line = 0; m_ok = 1; m_drop = 0;
    end else if (hr && m_active) begin
      if (m_x != H_PIXELS) begin m_short = 1; m_ok = 0; end
      m_x = 0;
      if (m_line + 1 >= V_LINES) begin m_ovr = 1; m_ok = 0; m_drop = 1; end
      else m_line++;
    end
    if (px && m_active && !m_drop) begin
      if (m_x >= H_PIXELS) begin m_ovr = 1; m_ok = 0; end
      else begin
        lbuf[m_x] = int'(col);
        if (m_x % 4 == 3) begin
          w.addr = (m_front ? 0 : BANK_BYTES) + m_line * BYTES_PER_LINE + m_x / 4;
          w.data = lbuf[m_x-3] * 64 + lbuf[m_x-2] * 16 + lbuf[m_x-1] * 4 + lbuf[m_x];
          exp_q.push_back(w);
        end
        m_x++;
      end
    end
  endfunction

  task automatic drv(input bit vs, input bit hs, input bit px, input logic [1:0] col);
    bus.lcd_vsync = vs; bus.lcd_hsync = hs; bus.lcd_pixel = px; bus.lcd_color = col;
    m_step(vs, hs, px, col, bus.capture_en);
    @(negedge clk);
  endtask

  task automatic do_line(input int n, input bit vs, input bit hs);
    for (int i = 0; i < n; i++) drv(vs && i == 0, hs && i == 0, 1'b1, 2'(i % 4));
  endtask

  task automatic do_frame(input int nlines);
    do_line(H_PIXELS, 1'b1, 1'b0);
    for (int l = 1; l < nlines; l++) do_line(H_PIXELS, 1'b0, 1'b1);
  endtask

  task automatic st_clear();
    n_we = 0; n_done = 0; n_bad = 0; a_min = 32'h7fffffff; a_max = -1;
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_we"},    32'(bus.fb_we), 0);
    chk({tag, "_waddr"}, 32'(bus.fb_waddr), 0);
    chk({tag, "_wdata"}, 32'(bus.fb_wdata), 0);
    chk({tag, "_front"}, 32'(bus.front_bank), 0);
    chk({tag, "_done"},  32'(bus.frame_done), 0);
    chk({tag, "_ovr"},   32'(bus.err_overrun), 0);
    chk({tag, "_short"}, 32'(bus.err_short), 0);
  endtask

  // per-cycle compare against the model
  initial begin
    wr_t w;
    forever begin
      @(posedge clk); #1;
      if (chk_en) begin
        if (bus.fb_we === 1'b1) begin
          n_we++;
          if (int'(bus.fb_waddr) < a_min) a_min = int'(bus.fb_waddr);
          if (int'(bus.fb_waddr) > a_max) a_max = int'(bus.fb_waddr);
          if (bus.fb_wdata != 8'h1B) n_bad++;
          last_addr = int'(bus.fb_waddr);
          last_data = int'(bus.fb_wdata);
          chk("waddr_range", 32'(int'(bus.fb_waddr) <= 2 * BANK_BYTES - 1), 1);
          chk("write_expected", 32'(exp_q.size() > 0), 1);
          if (exp_q.size() > 0) begin
            w = exp_q.pop_front();
            chk("waddr", 32'(bus.fb_waddr), w.addr);
            chk("wdata", 32'(bus.fb_wdata), w.data);
          end
        end
        chk("fb_we_known", 32'($isunknown(bus.fb_we)), 0);
        chk("missing_write", exp_q.size(), 0);
        chk("frame_done", 32'(bus.frame_done), 32'(m_done));
        chk("front_bank", 32'(bus.front_bank), 32'(m_front));
        chk("err_overrun", 32'(bus.err_overrun), 32'(m_ovr));
        chk("err_short", 32'(bus.err_short), 32'(m_short));
        if (bus.frame_done === 1'b1) n_done++;
      end
    end
  end

  initial begin
    rst = 1'b0;
    bus.capture_en = 1'b1;
    bus.lcd_vsync = 0; bus.lcd_hsync = 0; bus.lcd_pixel = 0; bus.lcd_color = 0;
    m_reset();
    st_clear();
    repeat (3) @(negedge clk);
    chk_outputs_zero("reset");
    chk_en = 1'b1;
    rst = 1'b1;

    // idle: pixels and hsync are ignored before the first vsync
    drv(0, 1, 1, 3);
    repeat (6) drv(0, 0, 1, 3);
    chk("idle_no_write", n_we, 0);

    // clean frame 1 into bank 1
    st_clear();
    do_frame(V_LINES);
    chk("f1_writes", n_we, 5760);
    chk("f1_data_1b", n_bad, 0);
    chk("f1_addr_min", a_min, 5760);
    chk("f1_addr_max", a_max, 11519);
    chk("f1_front_before", 32'(bus.front_bank), 0);

    // clean frame 2 back to back into bank 0; its vsync commits frame 1
    st_clear();
    do_frame(V_LINES);
    chk("f1_done_pulses", n_done, 1);
    chk("f1_front_after", 32'(bus.front_bank), 1);
    chk("f2_writes", n_we, 5760);
    chk("f2_data_1b", n_bad, 0);
    chk("f2_addr_min", a_min, 0);
    chk("f2_addr_max", a_max, 5759);

    // 161 px in line 0: commits frame 2, then overruns
    st_clear();
    do_line(H_PIXELS + 1, 1'b1, 1'b0);
    chk("f2_done_pulses", n_done, 1);
    chk("f2_front_after", 32'(bus.front_bank), 0);
    chk("ovr_flag", 32'(bus.err_overrun), 1);
    chk("ovr_writes", n_we, 40);
    chk("ovr_addr_min", a_min, 5760);
    chk("ovr_addr_max", a_max, 5799);

    // vsync + hsync + pixel in one cycle: no flip, pixel lands in [7:6] of byte 0
    st_clear();
    drv(1, 1, 1, 3);
    drv(0, 0, 1, 0); drv(0, 0, 1, 0); drv(0, 0, 1, 0);
    chk("same_no_flip", n_done, 0);
    chk("same_short", 32'(bus.err_short), 1);
    chk("same_writes", n_we, 1);
    chk("same_addr0", last_addr, 5760);
    chk("same_data0", last_data, 8'hC0);
    for (int i = 0; i < 4; i++) drv(0, 0, 1, 2'(i));
    chk("same_addr1", last_addr, 5761);
    chk("same_data1", last_data, 8'h1B);

    // reset at line 70
    do_frame(70);
    do_line(20, 1'b0, 1'b1);
    chk("pre_reset_ovr", 32'(bus.err_overrun), 1);
    rst = 1'b0;
    bus.lcd_vsync = 0; bus.lcd_hsync = 0; bus.lcd_pixel = 0; bus.lcd_color = 0;
    m_reset();
    @(negedge clk);
    chk_outputs_zero("midrst");
    @(negedge clk);
    rst = 1'b1;
    st_clear();
    drv(0, 1, 1, 2);
    repeat (10) drv(0, 0, 1, 1);
    chk("post_reset_no_write", n_we, 0);

    // line 10 cut to 158 px
    st_clear();
    do_frame(10);
    do_line(158, 1'b0, 1'b1);
    chk("short_before_hsync", 32'(bus.err_short), 0);
    do_line(H_PIXELS, 1'b0, 1'b1);
    chk("short_flag", 32'(bus.err_short), 1);
    chk("short_no_ovr", 32'(bus.err_overrun), 0);

    // next clean frame still commits; capture_en low at its closing vsync
    st_clear();
    do_frame(V_LINES);
    chk("f3_no_flip_at_start", n_done, 0);
    chk("f3_front_before", 32'(bus.front_bank), 0);
    chk("f3_writes", n_we, 5760);
    chk("f3_addr_min", a_min, 5760);
    st_clear();
    bus.capture_en = 1'b0;
    drv(1, 0, 0, 0);
    drv(0, 0, 0, 0);
    bus.capture_en = 1'b1;
    chk("f3_done_pulses", n_done, 1);
    chk("f3_front_after", 32'(bus.front_bank), 1);
    do_line(40, 1'b0, 1'b1);
    chk("final_idle_no_write", n_we, 0);
    repeat (3) drv(0, 0, 0, 0);
    chk("queue_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
